serial_parity_framer: RTL and testbench

SERIAL_PARITY_FRAMER -- requirements
Module: serial_parity_framer

---
 rtl/serial_parity_framer.sv | 93 +++++++++
 tb/tb_serial_parity_framer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_parity_framer.sv
// serial_parity_framer: deserialises LSB-first data words, each followed by one parity bit, and reports parity errors
//   clock, reset_n           : rising-edge clock, asynchronous active-low reset
//   x, x_valid               : serial bit and its qualifier (state advances only while x_valid=1)
//   odd_mode                 : 1 = odd parity, 0 = even; latched with bit 0 of each word
//   clear                    : synchronous abort of the partial word plus error-counter clear
//   z                        : running XOR of the data bits accepted so far in the current word
//   word_done                : one-cycle pulse the cycle after the parity bit is sampled
//   data_out, par_err        : last completed word and its parity error, held until the next word_done
//   err_count                : saturating count of errored words; counter present only with PARITY_ERR_CNT_EN
module serial_parity_framer #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 x,
  input  logic                 x_valid,
  input  logic                 odd_mode,
  input  logic                 clear,
  output logic                 z,
  output logic                 word_done,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 par_err,
  output logic [CNT_W-1:0]     err_count
);
  localparam int CW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  typedef enum logic {S_DATA, S_PAR} state_t;
  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 z_n, odd_l, odd_n, done_n, perr_n, last;
  assign last   = cnt == CW'(DATA_BITS - 1);
  // z already holds the XOR of all data bits when the parity bit arrives
  assign perr_n = z ^ x ^ odd_l;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    z_n     = z;
    odd_n   = odd_l;
    done_n  = 1'b0;
    if (clear) begin
      state_n = S_DATA;
      cnt_n   = '0;
      z_n     = 1'b0;
    end else if (x_valid) begin
      if (state == S_DATA) begin
        sh_n[cnt] = x;
        z_n       = z ^ x;
        odd_n     = cnt == '0 ? odd_mode : odd_l;
        cnt_n     = last ? '0 : cnt + 1'b1;
        state_n   = last ? S_PAR : S_DATA;
      end else begin
        state_n = S_DATA;
        z_n     = 1'b0;
        done_n  = 1'b1;
      end
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_DATA;
      cnt       <= '0;
      sh        <= '0;
      z         <= 1'b0;
      odd_l     <= 1'b0;
      word_done <= 1'b0;
      data_out  <= '0;
      par_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sh        <= sh_n;
      z         <= z_n;
      odd_l     <= odd_n;
      word_done <= done_n;
      if (done_n) begin
        data_out <= sh;
        par_err  <= perr_n;
      end
    end
  end
`ifdef PARITY_ERR_CNT_EN
  // counts at the completing edge so err_count is consistent with the word_done cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_count <= '0;
    else if (clear) err_count <= '0;
    else if (done_n && perr_n && !(&err_count)) err_count <= err_count + 1'b1;
  end
`else
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_serial_parity_framer.sv
// tb_serial_parity_framer: random and directed checks of serial_parity_framer against a queue-based word model
module tb_serial_parity_framer;
  localparam int DB = 4;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;
  logic clock = 1'b0, reset_n = 1'b0, x = 1'b0, x_valid = 1'b0, odd_mode = 1'b0, clear = 1'b0;
  logic z, word_done, par_err;
  logic [DB-1:0] data_out;
  logic [CW-1:0] err_count;
  int ncmp = 0, nerr = 0;
  serial_parity_framer #(.DATA_BITS(DB), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .x(x), .x_valid(x_valid), .odd_mode(odd_mode),
    .clear(clear), .z(z), .word_done(word_done), .data_out(data_out), .par_err(par_err),
    .err_count(err_count)
  );
  always #5 clock = ~clock;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  // model: bits of the current word in a queue; word result computed from ones-count
  bit bits[$];
  bit mode;
  bit m_done, m_perr;
  logic [DB-1:0] m_data;
  int m_cnt;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bits.delete();
      m_done = 0; m_perr = 0; m_data = '0; m_cnt = 0;
    end else begin
      m_done = 0;
      if (clear) begin
        bits.delete();
        m_cnt = 0;
      end else if (x_valid) begin
        if (bits.size() < DB) begin
          if (bits.size() == 0) mode = odd_mode;
          bits.push_back(x);
        end else begin
          for (int i = 0; i < DB; i++) m_data[i] = bits[i];
          m_perr = (($countones(m_data) + int'(x)) % 2) != int'(mode);
          m_done = 1;
          if (m_perr && m_cnt < CMAX) m_cnt++;
          bits.delete();
        end
      end
    end
  end
  function automatic bit m_z();
    bit r = 0;
    foreach (bits[i]) r ^= bits[i];
    return r;
  endfunction
  always @(posedge clock) begin
    #1;
    chk("z", z, m_z());
    chk("word_done", word_done, m_done);
    chk("data_out", data_out, m_data);
    chk("par_err", par_err, m_perr);
`ifdef PARITY_ERR_CNT_EN
    chk("err_count", err_count, m_cnt);
`else
    chk("err_count", err_count, 0);
`endif
  end
  task automatic drv(input bit v, input bit b);
    @(negedge clock);
    x_valid = v;
    x = b;
  endtask
  task automatic send(input logic [3:0] d, input bit p);
    for (int i = 0; i < 4; i++) drv(1, d[i]);
    drv(1, p);
    drv(0, 0);
  endtask
  int ec_tab[5];
  initial begin
`ifdef PARITY_ERR_CNT_EN
    ec_tab = '{1, 2, 3, 3, 3};
`else
    ec_tab = '{0, 0, 0, 0, 0};
`endif
    repeat (2) @(negedge clock);
    reset_n = 1;
    chk("rst_z", z, 0);
    chk("rst_done", word_done, 0);
    chk("rst_data", data_out, 0);
    chk("rst_perr", par_err, 0);
    chk("rst_cnt", err_count, 0);
    drv(1, 1); drv(1, 0); chk("r30_z0", z, 1);
    drv(1, 1); chk("r30_z1", z, 1);
    drv(1, 1); chk("r30_z2", z, 0);
    drv(1, 1); chk("r30_z3", z, 1);
    drv(0, 0);
    chk("r30_done", word_done, 1);
    chk("r30_data", data_out, 4'b1101);
    chk("r30_perr", par_err, 0);
    drv(0, 0); chk("r30_pulse", word_done, 0);
    send(4'b1101, 0);
    chk("r31_perr", par_err, 1);
`ifdef PARITY_ERR_CNT_EN
    chk("r31_cnt", err_count, 1);
`endif
    odd_mode = 1;
    drv(1, 1);
    @(negedge clock) odd_mode = 0;
    x = 0;
    drv(1, 1); drv(1, 1); drv(1, 0); drv(0, 0);
    chk("r32_done", word_done, 1);
    chk("r32_perr", par_err, 0);
    drv(1, 1); drv(1, 0);
    for (int i = 0; i < 3; i++) begin
      drv(0, 1);
      chk("r33_hold", z, 1);
    end
    drv(1, 1); drv(1, 1); drv(1, 1); drv(0, 0);
    chk("r33_data", data_out, 4'b1101);
    chk("r33_perr", par_err, 0);
    drv(1, 1); drv(1, 0); drv(1, 1);
    @(negedge clock) reset_n = 0;
    x_valid = 0;
    @(negedge clock) reset_n = 1;
    chk("r34_done", word_done, 0);
    chk("r34_data", data_out, 0);
    send(4'b0110, 0);
    chk("r34_wdone", word_done, 1);
    chk("r34_wdata", data_out, 4'b0110);
    chk("r34_wperr", par_err, 0);
    for (int k = 0; k < 5; k++) begin
      send(4'b0000, 1);
      chk("r35_cnt", err_count, ec_tab[k]);
    end
    drv(1, 1); drv(1, 1);
    @(negedge clock) clear = 1;
    x_valid = 1; x = 1;
    @(negedge clock) clear = 0;
    x_valid = 0;
    chk("r35_clr_cnt", err_count, 0);
    chk("r35_clr_z", z, 0);
    chk("r35_clr_data", data_out, 4'b0000);
    send(4'b1011, 1);
    chk("r35_after", data_out, 4'b1011);
    chk("r35_after_perr", par_err, 0);
    for (int i = 0; i < 4; i++) drv(1, 1);
    @(negedge clock) clear = 1;
    x_valid = 1; x = 1;
    @(negedge clock) clear = 0;
    x_valid = 0;
    chk("r25_nodone", word_done, 0);
    chk("r25_data", data_out, 4'b1011);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      x_valid = $urandom_range(0, 9) < 7;
      x = 1'($urandom);
      odd_mode = 1'($urandom);
      clear = $urandom_range(0, 49) == 0;
      reset_n = $urandom_range(0, 299) != 0;
    end
    @(negedge clock);
    reset_n = 1; clear = 0; x_valid = 0;
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
